lsu_rmw: RTL and testbench

- Load/store unit between the multicycle datapath's ALU address/B-register outputs and the 64-bit data memory; its output feeds the memory data register.
- Performs sub-doubleword loads with sign or zero extension.
- Performs sub-doubleword stores by read-modify-write, because the data memory has only a full 64-bit write enable.
- Sequenced by a small FSM with a req/done handshake to the control unit.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 74 +++++++
 rtl/lsu_rmw.sv | 187 ++++++++++++++++++
 tb/tb_lsu_rmw.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit:
//                FSM state encoding, RISC-V funct3 size/sign codes and a
//                helper returning the access size in bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes; bit 2 (unsigned flag) does not affect size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] sz;
        case (funct3)
            F3_B, F3_BU: sz = 4'd1;
            F3_H, F3_HU: sz = 4'd2;
            F3_W, F3_WU: sz = 4'd4;
            default:     sz = 4'd8;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational byte-lane steering for the LSU.
//                Extracts and sign/zero-extends a load lane from a memory
//                doubleword, and merges store bytes into a doubleword.
//                The offset is forced to natural alignment for the size, so
//                a misaligned offset is silently truncated.
//  Ports       : i_dword    - doubleword read from memory
//                i_offset   - byte offset within the doubleword
//                i_funct3   - RISC-V size/sign code
//                i_wdata    - store data, low bytes significant
//                o_load_val - extended load result
//                o_merged   - i_dword with the store bytes replaced
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_dword,
    input  logic [2:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load_val,
    output logic [63:0] o_merged
);

    logic [2:0]  w_eff_off;
    logic [5:0]  w_shamt;
    logic [63:0] w_lane;
    logic [63:0] w_wsh;
    logic [7:0]  w_bmask;
    logic [63:0] w_mask64;
    logic        w_sign;

    always_comb begin
        w_eff_off = i_offset;
        case (i_funct3[1:0])
            2'b01:   w_eff_off = {i_offset[2:1], 1'b0};
            2'b10:   w_eff_off = {i_offset[2], 2'b00};
            2'b11:   w_eff_off = 3'b000;
            default: w_eff_off = i_offset;
        endcase
    end

    assign w_shamt = {w_eff_off, 3'b000};
    assign w_lane  = i_dword >> w_shamt;
    assign w_wsh   = i_wdata << w_shamt;
    assign w_sign  = ~i_funct3[2];

    always_comb begin
        o_load_val = w_lane;
        case (i_funct3[1:0])
            2'b00:   o_load_val = {{56{w_sign & w_lane[7]}},  w_lane[7:0]};
            2'b01:   o_load_val = {{48{w_sign & w_lane[15]}}, w_lane[15:0]};
            2'b10:   o_load_val = {{32{w_sign & w_lane[31]}}, w_lane[31:0]};
            default: o_load_val = w_lane;
        endcase
    end

    // Byte enables: a run of size_bytes ones, shifted to the lane.
    assign w_bmask = (8'hFF >> (4'd8 - size_bytes(i_funct3))) << w_eff_off;

    always_comb begin
        w_mask64 = '0;
        for (int b = 0; b < 8; b++) begin
            w_mask64[8*b +: 8] = {8{w_bmask[b]}};
        end
    end

    assign o_merged = (i_dword & ~w_mask64) | (w_wsh & w_mask64);

endmodule
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_rmw
//  Description : Load/store unit for a 64-bit data memory that only supports
//                full-doubleword writes. Sub-doubleword loads are extracted
//                and extended; sub-doubleword stores are done by
//                read-modify-write. req/done handshake to the control unit.
//  Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned h/w/d
//                accesses complete with err=1 and no memory access. When
//                undefined, the offset is truncated to natural alignment and
//                the access proceeds; err flags only illegal funct3.
//  Parameters  : MEM_RD_LAT - cycles mem_raddr is held before mem_rdout is
//                             sampled (1..4)
//                ADDR_W     - address width
//  Ports       : clk, reset (async, active-low)
//                req/we/funct3/addr/wdata - request, sampled in IDLE only
//                rdata  - last successful load result
//                done   - one-cycle completion pulse; err valid with it
//                busy   - high outside IDLE
//                mem_raddr/mem_waddr/mem_wdata/mem_wr/mem_rdout - memory
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdout,
    output logic              mem_wr
);

    localparam logic [1:0] c_LAT_LAST = 2'(MEM_RD_LAT - 1);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        off_q, off_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;

    logic              w_illegal;
    logic              w_misalign;
    logic [63:0]       w_load_val;
    logic [63:0]       w_merged;

    lsu_lane_align u_align (
        .i_dword    (mem_rdout),
        .i_offset   (off_q),
        .i_funct3   (f3_q),
        .i_wdata    (wdata_q),
        .o_load_val (w_load_val),
        .o_merged   (w_merged)
    );

    // Checks are made on the live request inputs, used only in IDLE.
    assign w_illegal = we ? funct3[2] : (funct3 == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (funct3[1:0])
            2'b01:   w_misalign = addr[0];
            2'b10:   w_misalign = |addr[1:0];
            2'b11:   w_misalign = |addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    f3_d    = funct3;
                    off_d   = addr[2:0];
                    wdata_d = wdata;
                    raddr_d = {addr[ADDR_W-1:3], 3'b000};
                    waddr_d = {addr[ADDR_W-1:3], 3'b000};
                    cnt_d   = 2'd0;
                    if (w_illegal || w_misalign) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d = 1'b0;
                        // A full doubleword store needs no read phase.
                        if (we && (funct3 == F3_D)) begin
                            mem_wdata_d = wdata;
                            state_d     = WRITE;
                        end else begin
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == c_LAT_LAST) begin
                    if (we_q) begin
                        mem_wdata_d = w_merged;
                        state_d     = WRITE;
                    end else begin
                        rdata_d = w_load_val;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 3'b000;
            wdata_q     <= '0;
            cnt_q       <= 2'd0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Decoded from state so an asynchronous reset drops them immediately.
    assign done      = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign err       = done & err_q;
    assign mem_wr    = (state_q == WRITE);
    assign rdata     = rdata_q;
    assign mem_raddr = raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_rmw
//  Description : Scoreboard bench for lsu_rmw. A byte-addressed reference
//                model predicts responses and memory writes at issue time;
//                a monitor compares them whenever done or mem_wr appears.
//                Latency is the number of cycles from the req cycle through
//                the done cycle, inclusive.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_rmw;

    localparam int LAT = 1;
    localparam int AW  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          we;
    logic [2:0]    funct3;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    logic [63:0]   rdata;
    logic          done, busy, err;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [63:0]   mem_wdata, mem_rdout;
    logic          mem_wr;

    always #5 clk = ~clk;

    lsu_rmw #(.MEM_RD_LAT(LAT), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_rdout (mem_rdout),
        .mem_wr    (mem_wr)
    );

    // Physical memory seen by the DUT (256 doublewords, addresses < 0x800).
    logic [63:0] mem [0:255];
    always_comb mem_rdout = mem[mem_raddr[10:3]];

    // Reference model state: byte array and architectural rdata.
    logic [7:0]  rmem [0:2047];
    logic [63:0] model_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          rcyc;
    } resp_t;
    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT events against the scoreboard queues.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_mem_wr", 64'd1, 64'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("mem_waddr", mem_waddr, w.a);
                    check("mem_wdata", mem_wdata, w.d);
                end
                mem[mem_waddr[10:3]] = mem_wdata;
            end
            if (done) begin
                done_cnt++;
                if (resp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("err", {63'd0, err}, {63'd0, r.err});
                    check("rdata", rdata, r.rdata);
                    check("latency", 64'(cyc - r.rcyc + 1), 64'(r.lat));
                end
            end
        end
    end

    // Reference model plus driver for one request. With spur set, a second
    // request (an sd that would write memory) is held during the busy period.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input bit spur);
        int    sz;
        bit    bad;
        int    start;
        logic [63:0] ea, v, dw;
        resp_t r;
        @(negedge clk);
        start = done_cnt;
        sz    = 1 << f3[1:0];
        bad   = w ? f3[2] : (f3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % sz) != 0) bad = 1'b1;
`endif
        r.rcyc = cyc;
        if (bad) begin
            r.err = 1'b1; r.lat = 2; r.rdata = model_rdata;
        end else begin
            ea = a - (a % sz);
            r.err = 1'b0;
            if (w) begin
                wr_t wt;
                for (int i = 0; i < sz; i++) rmem[ea[10:0] + 11'(i)] = wd[8*i +: 8];
                dw = '0;
                for (int j = 0; j < 8; j++) dw[8*j +: 8] = rmem[{a[10:3], 3'b000} + 11'(j)];
                wt.a = {a[63:3], 3'b000};
                wt.d = dw;
                wr_q.push_back(wt);
                r.lat = (sz == 8) ? 3 : LAT + 3;
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = rmem[ea[10:0] + 11'(i)];
                if (!f3[2] && sz < 8)
                    for (int i = 8*sz; i < 64; i++) v[i] = v[8*sz-1];
                model_rdata = v;
                r.lat = LAT + 2;
            end
            r.rdata = model_rdata;
        end
        resp_q.push_back(r);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        if (spur) begin
            we = 1'b1; funct3 = 3'b011; addr = 64'h40; wdata = 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
        end
        req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (done_cnt != start) break;
            @(negedge clk);
        end
        if (spur) repeat (6) @(negedge clk);
        #1;
        check(spur ? "single_done_busy_req" : "done_seen", 64'(done_cnt - start), 64'd1);
    endtask

    initial begin
        logic [63:0] d;
        reset = 1'b0; req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        model_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            d = (i == 2) ? 64'h8877665544332211 : {$urandom, $urandom};
            mem[i] = d;
            for (int j = 0; j < 8; j++) rmem[i*8 + j] = d[8*j +: 8];
        end
        #1;
        check("reset_outputs", {rdata, mem_raddr, mem_waddr, mem_wdata},
              {64'd0, 64'd0, 64'd0, 64'd0});
        check("reset_flags", {60'd0, done, busy, err, mem_wr}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        issue(1'b0, 3'b000, 64'h17, 64'd0, 1'b0);                    // lb
        issue(1'b0, 3'b101, 64'h12, 64'd0, 1'b0);                    // lhu
        issue(1'b0, 3'b010, 64'h14, 64'd0, 1'b0);                    // lw
        issue(1'b1, 3'b000, 64'h11, 64'hAB, 1'b0);                   // sb
        issue(1'b0, 3'b011, 64'h10, 64'd0, 1'b0);                    // ld
        issue(1'b1, 3'b011, 64'h20, 64'h0123456789ABCDEF, 1'b0);     // sd
        issue(1'b1, 3'b010, 64'h12, 64'hCAFEF00D_11223344, 1'b0);    // sw misaligned
        issue(1'b0, 3'b111, 64'h08, 64'd0, 1'b0);                    // illegal load
        issue(1'b1, 3'b100, 64'h08, 64'h55, 1'b0);                   // illegal store
        issue(1'b0, 3'b110, 64'h14, 64'd0, 1'b1);                    // lwu + req while busy

        // Reset during the read phase of an sb: no write may follow.
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 64'h11; wdata = 64'hCD;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_outputs", {rdata, mem_raddr, mem_waddr, mem_wdata},
              {64'd0, 64'd0, 64'd0, 64'd0});
        check("abort_flags", {60'd0, done, busy, err, mem_wr}, 64'd0);
        model_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_wr", {63'd0, mem_wr}, 64'd0);
        end
        reset = 1'b1;
        issue(1'b0, 3'b011, 64'h10, 64'd0, 1'b0);

        repeat (150) begin
            logic [63:0] a;
            a = 64'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 1) a = a & ~64'd7;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                  {$urandom, $urandom}, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("queues_drained", 64'(resp_q.size() + wr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
